// File: rtl/branch_ctrl_pkg.sv
// rtl/branch_ctrl_pkg.sv - shared decode constants, FSM states and branch classifier
//
// Purpose: opcode/funct/REGIMM-rt encodings for MIPS control transfers, the
//          branch_ctrl FSM state encoding, and a classifier that turns the
//          decode fields into the attributes the controller and the hazard
//          detector need.
// Ports:   none (package).
package branch_ctrl_pkg;

  // Primary opcodes
  localparam logic [5:0] EXE_SPECIAL_INST = 6'b000000;
  localparam logic [5:0] EXE_REGIMM_INST  = 6'b000001;
  localparam logic [5:0] EXE_J            = 6'b000010;
  localparam logic [5:0] EXE_JAL          = 6'b000011;
  localparam logic [5:0] EXE_BEQ          = 6'b000100;
  localparam logic [5:0] EXE_BNE          = 6'b000101;
  localparam logic [5:0] EXE_BLEZ         = 6'b000110;
  localparam logic [5:0] EXE_BGTZ         = 6'b000111;

  // REGIMM subcodes carried in rt
  localparam logic [4:0] EXE_BLTZ         = 5'b00000;
  localparam logic [4:0] EXE_BGEZ         = 5'b00001;
  localparam logic [4:0] EXE_BLTZAL       = 5'b10000;
  localparam logic [4:0] EXE_BGEZAL       = 5'b10001;

  // SPECIAL funct codes
  localparam logic [5:0] EXE_JR           = 6'b001000;
  localparam logic [5:0] EXE_JALR         = 6'b001001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SLOT = 2'd2
  } br_state_e;

  typedef enum logic [1:0] {
    TGT_BR = 2'd0,
    TGT_J  = 2'd1,
    TGT_JR = 2'd2
  } tgt_sel_e;

  typedef struct packed {
    logic     is_ct;    // control transfer of any kind
    logic     is_cond;  // outcome depends on cmp_y (and is counted)
    logic     is_link;  // writes PC+8 to the link register
    logic     use_rs;
    logic     use_rt;
    tgt_sel_e tsel;
  } br_class_t;

  function automatic br_class_t classify(input logic [5:0] op,
                                         input logic [4:0] rt,
                                         input logic [5:0] funct);
    br_class_t c;
    c = '0;
    case (op)
      EXE_BEQ, EXE_BNE: begin
        c.is_ct   = 1'b1;
        c.is_cond = 1'b1;
        c.use_rs  = 1'b1;
        c.use_rt  = 1'b1;
        c.tsel    = TGT_BR;
      end
      EXE_BGTZ, EXE_BLEZ: begin
        c.is_ct   = 1'b1;
        c.is_cond = 1'b1;
        c.use_rs  = 1'b1;
        c.tsel    = TGT_BR;
      end
      EXE_REGIMM_INST: begin
        if (rt == EXE_BLTZ || rt == EXE_BGEZ || rt == EXE_BLTZAL || rt == EXE_BGEZAL) begin
          c.is_ct   = 1'b1;
          c.is_cond = 1'b1;
          c.use_rs  = 1'b1;
          c.is_link = (rt == EXE_BLTZAL) || (rt == EXE_BGEZAL);
          c.tsel    = TGT_BR;
        end
      end
      EXE_J, EXE_JAL: begin
        c.is_ct   = 1'b1;
        c.is_link = (op == EXE_JAL);
        c.tsel    = TGT_J;
      end
      EXE_SPECIAL_INST: begin
        if (funct == EXE_JR || funct == EXE_JALR) begin
          c.is_ct   = 1'b1;
          c.use_rs  = 1'b1;
          c.is_link = (funct == EXE_JALR);
          c.tsel    = TGT_JR;
        end
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/branch_hazard_det.sv
// rtl/branch_hazard_det.sv - RAW hazard check for branch source operands in ID
//
// Purpose: flags when a source register the ID-stage branch compares is still
//          being produced by an ALU op in EX or a load in MEM.
// Ports:   use_rs/use_rt  which decode fields are real sources
//          id_rs/id_rt    source register numbers
//          ex_regwrite/ex_writereg    EX destination
//          mem_memtoreg/mem_writereg  MEM load destination
//          hazard         operand not yet available to eqcmp
module branch_hazard_det (
  input  logic       use_rs,
  input  logic       use_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_regwrite,
  input  logic [4:0] ex_writereg,
  input  logic       mem_memtoreg,
  input  logic [4:0] mem_writereg,
  output logic       hazard
);

  logic rs_hit;
  logic rt_hit;

  // $0 is hardwired, so a write targeting it never blocks a branch.
  // A non-load in MEM is already forwardable, hence only loads count there.
  assign rs_hit = use_rs && (id_rs != 5'd0) &&
                  ((ex_regwrite && (id_rs == ex_writereg)) ||
                   (mem_memtoreg && (id_rs == mem_writereg)));

  assign rt_hit = use_rt && (id_rt != 5'd0) &&
                  ((ex_regwrite && (id_rt == ex_writereg)) ||
                   (mem_memtoreg && (id_rt == mem_writereg)));

  assign hazard = rs_hit || rt_hit;

endmodule

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - ID-stage branch/jump resolution sequencer
//
// Purpose: waits for branch operands, resolves the branch in ID, drives the
//          PC redirect, tracks the delay slot, requests link writes and
//          counts conditional-branch outcomes.
// Ports:   clk, resetn (async, active low)
//          id_valid, id_op, id_rt, id_rs, id_funct  ID decode fields
//          cmp_y                      eqcmp condition result
//          ex_regwrite/ex_writereg, mem_memtoreg/mem_writereg  producers
//          stall_in, flush_exc        global stall / exception flush
//          br_target, j_target, jr_target  candidate redirect addresses
//          stall_id                   hold IF/ID while operands pending
//          redirect_valid/redirect_pc PC redirect
//          id_in_dslot                ID holds a delay-slot instruction
//          link_we                    write PC+8 to the link register
//          perf_taken/perf_ntaken     conditional-branch outcome counters
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              id_valid,
  input  logic [5:0]        id_op,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rs,
  input  logic [5:0]        id_funct,
  input  logic              cmp_y,
  input  logic              ex_regwrite,
  input  logic [4:0]        ex_writereg,
  input  logic              mem_memtoreg,
  input  logic [4:0]        mem_writereg,
  input  logic              stall_in,
  input  logic              flush_exc,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [ADDR_W-1:0] j_target,
  input  logic [ADDR_W-1:0] jr_target,
  output logic              stall_id,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              id_in_dslot,
  output logic              link_we,
  output logic [PERF_W-1:0] perf_taken,
  output logic [PERF_W-1:0] perf_ntaken
);

  br_class_t         cls;
  logic              hazard;
  br_state_e         state_q;
  br_state_e         state_d;
  logic              dslot_q;
  logic              dslot_d;
  logic [PERF_W-1:0] perf_taken_q;
  logic [PERF_W-1:0] perf_ntaken_q;
  logic              ct_active;
  logic              taken;
  logic              out_en;
  logic              cnt_taken;
  logic              cnt_ntaken;
  logic              stall_c;
  logic              redir_c;
  logic [ADDR_W-1:0] redir_pc_c;
  logic              link_c;

  assign cls = classify(id_op, id_rt, id_funct);

  branch_hazard_det u_hazard (
    .use_rs       (cls.use_rs),
    .use_rt       (cls.use_rt),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_regwrite  (ex_regwrite),
    .ex_writereg  (ex_writereg),
    .mem_memtoreg (mem_memtoreg),
    .mem_writereg (mem_writereg),
    .hazard       (hazard)
  );

  // Only IDLE and WAIT evaluate the ID instruction; in SLOT the ID stage holds
  // the delay slot, which is never resolved until the FSM is back in IDLE.
  assign ct_active = id_valid && cls.is_ct && ((state_q == IDLE) || (state_q == WAIT));
  assign taken     = cls.is_cond ? cmp_y : 1'b1;

  // Output gate only; resetn is kept out of every flop D path.
  assign out_en = resetn && !flush_exc;

  always_comb begin
    state_d    = state_q;
    stall_c    = 1'b0;
    redir_c    = 1'b0;
    redir_pc_c = '0;
    link_c     = 1'b0;
    cnt_taken  = 1'b0;
    cnt_ntaken = 1'b0;

    case (state_q)
      IDLE:    if (ct_active) state_d = hazard ? WAIT : SLOT;
      WAIT:    if (!ct_active) state_d = IDLE;
               else            state_d = hazard ? WAIT : SLOT;
      SLOT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (ct_active) begin
      if (hazard) begin
        stall_c = 1'b1;
      end else begin
        redir_c = taken;
        if (taken) begin
          case (cls.tsel)
            TGT_BR:  redir_pc_c = br_target;
            TGT_J:   redir_pc_c = j_target;
            default: redir_pc_c = jr_target;
          endcase
        end
        link_c     = cls.is_link;
        cnt_taken  = cls.is_cond && taken;
        cnt_ntaken = cls.is_cond && !taken;
      end
    end

    // A global stall freezes sequencing; the combinational resolution keeps
    // being presented so the redirect stays stable until the stall lifts.
    if (stall_in) begin
      state_d    = state_q;
      cnt_taken  = 1'b0;
      cnt_ntaken = 1'b0;
    end

    if (flush_exc) begin
      state_d    = IDLE;
      cnt_taken  = 1'b0;
      cnt_ntaken = 1'b0;
    end

    dslot_d = (state_d == SLOT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      dslot_q       <= 1'b0;
      perf_taken_q  <= '0;
      perf_ntaken_q <= '0;
    end else begin
      state_q <= state_d;
      dslot_q <= dslot_d;
      if (cnt_taken)  perf_taken_q  <= perf_taken_q + PERF_W'(1);
      if (cnt_ntaken) perf_ntaken_q <= perf_ntaken_q + PERF_W'(1);
    end
  end

  assign stall_id       = out_en && stall_c;
  assign redirect_valid = out_en && redir_c;
  assign redirect_pc    = out_en ? redir_pc_c : '0;
  assign link_we        = out_en && link_c;
  assign id_in_dslot    = dslot_q;
  assign perf_taken     = perf_taken_q;
  assign perf_ntaken    = perf_ntaken_q;

endmodule
